// File: rtl/gate_config_change_sm_pkg.sv
// Shared PTP time types and {sec,ns} arithmetic for the gate schedule controller.
package gate_config_change_sm_pkg;

    localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

    typedef struct packed {
        logic [47:0] sec;
        logic [31:0] ns;
    } ptp_time_t;

    // Add a sub-second nanosecond amount to a normalised time, carrying into seconds.
    function automatic ptp_time_t time_add_ns(input ptp_time_t t, input logic [31:0] c);
        ptp_time_t   r;
        logic [32:0] sum;
        logic [32:0] wrapped;
        sum     = {1'b0, t.ns} + {1'b0, c};
        wrapped = sum - {1'b0, NS_PER_SEC};
        if (sum >= {1'b0, NS_PER_SEC}) begin
            r.sec = t.sec + 48'd1;
            r.ns  = wrapped[31:0];
        end else begin
            r.sec = t.sec;
            r.ns  = sum[31:0];
        end
        return r;
    endfunction

    // a >= b on normalised {sec,ns} values.
    function automatic logic time_ge(input ptp_time_t a, input ptp_time_t b);
        return (a.sec > b.sec) || ((a.sec == b.sec) && (a.ns >= b.ns));
    endfunction

endpackage

// File: rtl/gate_config_change_sm_ptp_time_adder.sv
// Combinational {sec,ns} + ns adder with nanosecond rollover.
module ptp_time_adder
    import gate_config_change_sm_pkg::*;
(
    input  ptp_time_t   t_in,
    input  logic [31:0] add_ns,
    output ptp_time_t   t_out
);

    assign t_out = time_add_ns(t_in, add_ns);

endmodule

// File: rtl/gate_config_change_sm.sv
// Admin->oper schedule swap controller and PTP-aligned cycle start generator.
module gate_config_change_sm
    import gate_config_change_sm_pkg::*;
#(
    parameter int unsigned MIN_CYCLE_NS = 64,
    parameter int unsigned MAX_ITER     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] sync_time_ptp_sec,
    input  logic [31:0] sync_time_ptp_ns,
    input  logic [47:0] admin_base_sec,
    input  logic [31:0] admin_base_ns,
    input  logic [31:0] admin_cycle_ns,
    input  logic        config_change,
    output logic        CycleStart,
    output logic        ConfigSwap,
    output logic        ConfigPending,
    output logic        ConfigError,
    output logic        OperValid,
    output logic [31:0] OperCycleTime
);

    localparam int ITER_W = $clog2(MAX_ITER + 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CHECK   = 2'd1;
    localparam logic [1:0] ST_CALC    = 2'd2;
    localparam logic [1:0] ST_PENDING = 2'd3;

    ptp_time_t          now;
    logic [1:0]         state_reg;
    ptp_time_t          adm_base_reg;
    logic [31:0]        adm_cycle_reg;
    ptp_time_t          target_reg;
    logic [ITER_W-1:0]  iter_reg;
    ptp_time_t          next_start_reg;
    logic               hit_prev_reg;

    ptp_time_t          target_step;
    ptp_time_t          next_base;
    logic [31:0]        next_add;
    ptp_time_t          next_start_step;
    logic               cycle_ok;
    logic               swap_now;
    logic               oper_hit;

    assign now      = {sync_time_ptp_sec, sync_time_ptp_ns};
    assign cycle_ok = (adm_cycle_reg >= MIN_CYCLE_NS) && (adm_cycle_reg < NS_PER_SEC);
    // A fresh config_change request pre-empts a swap that would otherwise fire this clock.
    assign swap_now = (state_reg == ST_PENDING) && !config_change && time_ge(now, target_reg);
    assign oper_hit = OperValid && time_ge(now, next_start_reg);

    // On a swap the next boundary is measured from the new schedule's start, so the old cycle is truncated.
    assign next_base = swap_now ? target_reg    : next_start_reg;
    assign next_add  = swap_now ? adm_cycle_reg : OperCycleTime;

    ptp_time_adder u_target_adder (
        .t_in   (target_reg),
        .add_ns (adm_cycle_reg),
        .t_out  (target_step)
    );

    ptp_time_adder u_next_adder (
        .t_in   (next_base),
        .add_ns (next_add),
        .t_out  (next_start_step)
    );

    // Config-change sequencer: latch, validate, roll target forward, wait for swap time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            adm_base_reg  <= '0;
            adm_cycle_reg <= '0;
            target_reg    <= '0;
            iter_reg      <= '0;
            ConfigPending <= 1'b0;
            ConfigError   <= 1'b0;
            ConfigSwap    <= 1'b0;
        end else begin
            ConfigError <= 1'b0;
            ConfigSwap  <= 1'b0;
            if (config_change) begin
                adm_base_reg  <= {admin_base_sec, admin_base_ns};
                adm_cycle_reg <= admin_cycle_ns;
                ConfigPending <= 1'b1;
                state_reg     <= ST_CHECK;
            end else begin
                case (state_reg)
                    ST_CHECK: begin
                        if (!cycle_ok) begin
                            ConfigError   <= 1'b1;
                            ConfigPending <= 1'b0;
                            state_reg     <= ST_IDLE;
                        end else begin
                            target_reg <= adm_base_reg;
                            iter_reg   <= '0;
                            state_reg  <= time_ge(adm_base_reg, now) ? ST_PENDING : ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        target_reg <= target_step;
                        iter_reg   <= iter_reg + ITER_W'(1);
                        if (time_ge(target_step, now)) begin
                            state_reg <= ST_PENDING;
                        end else if (iter_reg == ITER_LAST) begin
                            ConfigError   <= 1'b1;
                            ConfigPending <= 1'b0;
                            state_reg     <= ST_IDLE;
                        end
                    end
                    ST_PENDING: begin
                        if (swap_now) begin
                            ConfigSwap    <= 1'b1;
                            ConfigPending <= 1'b0;
                            state_reg     <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    // Oper cycle generator: one CycleStart per run of consecutive boundary hits, swap overrides.
    always_ff @(posedge clk) begin
        if (rst) begin
            OperValid      <= 1'b0;
            OperCycleTime  <= '0;
            next_start_reg <= '0;
            hit_prev_reg   <= 1'b0;
            CycleStart     <= 1'b0;
        end else begin
            CycleStart <= 1'b0;
            if (swap_now) begin
                OperValid      <= 1'b1;
                OperCycleTime  <= adm_cycle_reg;
                next_start_reg <= next_start_step;
                hit_prev_reg   <= 1'b1;
                CycleStart     <= 1'b1;
            end else begin
                hit_prev_reg <= oper_hit;
                if (oper_hit) begin
                    next_start_reg <= next_start_step;
                    CycleStart     <= !hit_prev_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_config_change_sm.sv
// Self-checking bench: integer-nanosecond reference model plus per-scenario checks.
module tb_gate_config_change_sm;

    localparam longint NS = 1_000_000_000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] sync_sec = '0;
    logic [31:0] sync_ns = '0;
    logic [47:0] admin_base_sec = '0;
    logic [31:0] admin_base_ns = '0;
    logic [31:0] admin_cycle_ns = '0;
    logic        config_change = 1'b0;
    logic        CycleStart, ConfigSwap, ConfigPending, ConfigError, OperValid;
    logic [31:0] OperCycleTime;

    gate_config_change_sm dut (
        .clk               (clk),
        .rst               (rst),
        .sync_time_ptp_sec (sync_sec),
        .sync_time_ptp_ns  (sync_ns),
        .admin_base_sec    (admin_base_sec),
        .admin_base_ns     (admin_base_ns),
        .admin_cycle_ns    (admin_cycle_ns),
        .config_change     (config_change),
        .CycleStart        (CycleStart),
        .ConfigSwap        (ConfigSwap),
        .ConfigPending     (ConfigPending),
        .ConfigError       (ConfigError),
        .OperValid         (OperValid),
        .OperCycleTime     (OperCycleTime)
    );

    always #4 clk = ~clk;

    int     vectors = 0;
    int     miscompares = 0;
    longint now_t = 0;
    longint last_sample = 0;

    // Reference model: times are plain integer nanoseconds since PTP epoch.
    typedef enum {M_IDLE, M_CHECK, M_CALC, M_PEND} mphase_t;
    mphase_t m_phase;
    longint  m_base, m_cyc, m_target, m_iter, m_oct, m_next;
    bit      m_val, m_prev, m_cs, m_sw, m_err, m_pend;

    wire [36:0] dut_vec = {CycleStart, ConfigSwap, ConfigError, ConfigPending, OperValid, OperCycleTime};

    function automatic logic [36:0] mdl_vec();
        logic [31:0] oct;
        oct = m_oct[31:0];
        return {m_cs, m_sw, m_err, m_pend, m_val, oct};
    endfunction

    task automatic drive_time();
        sync_sec = 48'(now_t / NS);
        sync_ns  = 32'(now_t % NS);
    endtask

    task automatic set_admin(input longint base, input longint cyc);
        admin_base_sec = 48'(base / NS);
        admin_base_ns  = 32'(base % NS);
        admin_cycle_ns = 32'(cyc);
        config_change  = 1'b1;
    endtask

    task automatic model_step();
        longint now;
        longint nn;
        bit     hit;
        bit     np;
        now = now_t;
        if (rst) begin
            m_phase = M_IDLE; m_base = 0; m_cyc = 0; m_target = 0; m_iter = 0;
            m_oct = 0; m_next = 0; m_val = 0; m_prev = 0;
            m_cs = 0; m_sw = 0; m_err = 0; m_pend = 0;
            return;
        end
        m_sw = 0; m_err = 0;
        hit  = m_val && (now >= m_next);
        nn   = hit ? m_next + m_oct : m_next;
        np   = hit;
        m_cs = hit && !m_prev;
        if (config_change) begin
            m_base  = longint'(admin_base_sec) * NS + longint'(admin_base_ns);
            m_cyc   = longint'(admin_cycle_ns);
            m_pend  = 1;
            m_phase = M_CHECK;
        end else begin
            case (m_phase)
                M_CHECK: begin
                    if (m_cyc < 64 || m_cyc >= NS) begin
                        m_err = 1; m_pend = 0; m_phase = M_IDLE;
                    end else begin
                        m_target = m_base;
                        m_iter   = 0;
                        m_phase  = (m_base >= now) ? M_PEND : M_CALC;
                    end
                end
                M_CALC: begin
                    m_target = m_target + m_cyc;
                    m_iter   = m_iter + 1;
                    if (m_target >= now) m_phase = M_PEND;
                    else if (m_iter == 1024) begin
                        m_err = 1; m_pend = 0; m_phase = M_IDLE;
                    end
                end
                M_PEND: begin
                    if (now >= m_target) begin
                        m_sw = 1; m_cs = 1; m_val = 1; m_oct = m_cyc;
                        nn = m_target + m_cyc; np = 1; m_pend = 0; m_phase = M_IDLE;
                    end
                end
                default: ;
            endcase
        end
        m_next = nn;
        m_prev = np;
    endtask

    // Advance one clock: model and DUT see the same inputs, then PTP time moves on by 8 ns.
    task automatic tick();
        model_step();
        last_sample = now_t;
        @(posedge clk);
        #1;
        config_change = 1'b0;
        now_t += 8;
        drive_time();
    endtask

    task automatic do_reset(input longint start);
        rst = 1'b1;
        config_change = 1'b0;
        now_t = start;
        drive_time();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(NS - 1000);
        vectors++;
        if (dut_vec !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0", dut_vec);
        end
        for (int i = 0; i < 3; i++) begin
            tick(); vectors++;
            if (dut_vec !== mdl_vec()) begin
                miscompares++;
                $display("FAIL reset_idle[%0d]: got %h expected %h", i, dut_vec, mdl_vec());
            end
        end
    endtask

    task automatic test_future_base();
        longint swap_at = -1;
        int     swaps = 0;
        int     last_cs = -1;
        do_reset(NS - 1000);
        set_admin(NS, 1000);
        for (int i = 0; i < 600; i++) begin
            tick(); vectors++;
            if (dut_vec !== mdl_vec()) begin
                miscompares++;
                $display("FAIL future_base[%0d]: got %h expected %h", i, dut_vec, mdl_vec());
            end
            if (ConfigSwap) begin swaps++; swap_at = last_sample; end
            if (CycleStart) begin
                if (last_cs >= 0) begin
                    vectors++;
                    if (i - last_cs != 125) begin
                        miscompares++;
                        $display("FAIL future_period: got %0d clks expected 125", i - last_cs);
                    end
                end
                last_cs = i;
            end
        end
        vectors++;
        if (swaps != 1 || swap_at != NS) begin
            miscompares++;
            $display("FAIL future_swap: got %0d swaps at %0d expected 1 at %0d", swaps, swap_at, NS);
        end
        vectors++;
        if (OperCycleTime !== 32'd1000) begin
            miscompares++;
            $display("FAIL future_cycle: got %0d expected 1000", OperCycleTime);
        end
    endtask

    task automatic test_past_base();
        longint swap_at = -1;
        int     errs = 0;
        do_reset(NS - 800);
        set_admin(NS - 10_000, 1000);
        for (int i = 0; i < 300; i++) begin
            tick(); vectors++;
            if (dut_vec !== mdl_vec()) begin
                miscompares++;
                $display("FAIL past_base[%0d]: got %h expected %h", i, dut_vec, mdl_vec());
            end
            if (ConfigSwap) swap_at = last_sample;
            if (ConfigError) errs++;
        end
        vectors++;
        if (swap_at != NS || errs != 0) begin
            miscompares++;
            $display("FAIL past_swap: got swap at %0d, %0d errors expected %0d, 0", swap_at, errs, NS);
        end
    endtask

    task automatic test_errors();
        int err_tick;
        int errs;
        for (int k = 0; k < 3; k++) begin
            longint cyc;
            longint base;
            int     expect_tick;
            cyc  = (k == 0) ? longint'($urandom_range(0, 63)) : ((k == 1) ? NS : 64);
            base = (k == 2) ? 0 : now_t + 5000;
            expect_tick = (k == 2) ? 1025 : 1;
            set_admin(base, cyc);
            err_tick = -1; errs = 0;
            for (int i = 0; i < 1040; i++) begin
                tick(); vectors++;
                if (dut_vec !== mdl_vec()) begin
                    miscompares++;
                    $display("FAIL errors%0d[%0d]: got %h expected %h", k, i, dut_vec, mdl_vec());
                end
                if (ConfigError) begin errs++; err_tick = i; end
            end
            vectors++;
            if (errs != 1 || err_tick != expect_tick || OperValid !== 1'b1 || ConfigPending !== 1'b0) begin
                miscompares++;
                $display("FAIL error_pulse%0d: got %0d pulses at clk %0d valid %b expected 1 at %0d valid 1",
                         k, errs, err_tick, OperValid, expect_tick);
            end
        end
    endtask

    task automatic test_ptp_jump();
        bit found = 0;
        int pulses = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick(); vectors++;
            if (dut_vec !== mdl_vec()) begin
                miscompares++;
                $display("FAIL jump_wait[%0d]: got %h expected %h", i, dut_vec, mdl_vec());
            end
            if (CycleStart) found = 1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL jump_wait: got no CycleStart expected one within 300 clks");
        end
        repeat (20) tick();
        now_t += 10_000;
        drive_time();
        for (int i = 0; i < 30; i++) begin
            tick(); vectors++;
            if (dut_vec !== mdl_vec()) begin
                miscompares++;
                $display("FAIL jump[%0d]: got %h expected %h", i, dut_vec, mdl_vec());
            end
            if (CycleStart) pulses++;
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL jump_pulses: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_live_change();
        longint base;
        int     swaps = 0;
        int     last_cs = -1;
        int     post = 0;
        bit     swapped = 0;
        base = ((now_t - NS) / 1000 + 3) * 1000 + NS;
        set_admin(base, 2000);
        for (int i = 0; i < 1100; i++) begin
            tick(); vectors++;
            if (dut_vec !== mdl_vec()) begin
                miscompares++;
                $display("FAIL live[%0d]: got %h expected %h", i, dut_vec, mdl_vec());
            end
            if (CycleStart) begin
                if (last_cs >= 0) begin
                    vectors++;
                    if (i - last_cs != (swapped ? 250 : 125)) begin
                        miscompares++;
                        $display("FAIL live_period: got %0d clks expected %0d", i - last_cs, swapped ? 250 : 125);
                    end
                    if (swapped) post++;
                end
                last_cs = i;
            end
            if (ConfigSwap) begin
                swaps++;
                swapped = 1;
                vectors++;
                if (CycleStart !== 1'b1 || last_sample != base) begin
                    miscompares++;
                    $display("FAIL live_swap: got CycleStart %b at %0d expected 1 at %0d", CycleStart, last_sample, base);
                end
            end
        end
        vectors++;
        if (swaps != 1 || post < 2) begin
            miscompares++;
            $display("FAIL live_count: got %0d swaps %0d periods expected 1 swap >=2 periods", swaps, post);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int     sel;
            int     n;
            longint cyc;
            longint base;
            sel  = $urandom_range(0, 9);
            cyc  = (sel == 0) ? longint'($urandom_range(0, 63)) :
                   ((sel == 1) ? 64 : longint'($urandom_range(64, 3000)));
            base = now_t + longint'($urandom_range(0, 8000)) - 4000;
            set_admin(base, cyc);
            n = $urandom_range(100, 900);
            for (int i = 0; i < n; i++) begin
                tick(); vectors++;
                if (dut_vec !== mdl_vec()) begin
                    miscompares++;
                    $display("FAIL random%0d[%0d]: got %h expected %h", r, i, dut_vec, mdl_vec());
                end
                if (i == 3 && $urandom_range(0, 3) == 0)
                    set_admin(now_t + longint'($urandom_range(0, 3000)), longint'($urandom_range(64, 2000)));
                if (i == 60 && $urandom_range(0, 2) == 0) begin
                    now_t += ($urandom_range(0, 1) == 0) ? 3000 : -1500;
                    drive_time();
                end
            end
        end
    endtask

    task automatic test_reset_pending();
        int swaps = 0;
        set_admin(now_t + 4000, 1000);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        vectors++;
        if (dut_vec !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_pending: got %h expected 0", dut_vec);
        end
        rst = 1'b0;
        for (int i = 0; i < 700; i++) begin
            tick(); vectors++;
            if (dut_vec !== mdl_vec()) begin
                miscompares++;
                $display("FAIL after_reset[%0d]: got %h expected %h", i, dut_vec, mdl_vec());
            end
            if (ConfigSwap) swaps++;
        end
        vectors++;
        if (swaps != 0 || OperValid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_discard: got %0d swaps valid %b expected 0 swaps valid 0", swaps, OperValid);
        end
    endtask

    initial begin
        drive_time();
        test_reset();
        test_future_base();
        test_past_base();
        test_errors();
        test_ptp_jump();
        test_live_change();
        test_random();
        test_reset_pending();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
